lcd_static_drv: RTL and testbench

LCD_STATIC_DRV -- requirements
Module: lcd_static_drv

---
 rtl/lcd_defs.sv | 33 +++
 rtl/bcd7seg.sv | 27 ++
 rtl/lcd_static_drv.sv | 128 ++++++++++++
 tb/tb_lcd_static_drv.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_defs.sv
// Shared definitions for the static two-digit LCD driver: segment codes,
// FSM state encoding and the captured display request record.
package lcd_defs;

   // Segment codes in gfedcba order (bit 0 = segment a).
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Load handshake state: IDLE accepts a new value, PEND holds one until
   // the next frame boundary.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   // Raw display request as captured on an accepted load.
   typedef struct packed {
      logic       blank;
      logic [1:0] dp;
      logic [7:0] digits;
   } disp_req_t;

endpackage

// File: rtl/bcd7seg.sv
// BCD to seven-segment decoder (gfedcba); codes 10..15 show a dash.
module bcd7seg
   import lcd_defs::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   // Pure lookup of the segment pattern for one digit.
   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/lcd_static_drv.sv
// Static-drive LCD controller for two 7-segment digits with decimal points.
// A prescaler makes the backplane square wave; segment pins are the active
// pattern XORed with the backplane so lit segments sit in anti-phase.
// New values are only swapped in on the bp 1->0 edge so every pattern is
// held for whole backplane periods and the glass stays DC balanced.
module lcd_static_drv
   import lcd_defs::*;
#(
   parameter int BP_DIV   = 32,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        osc_sclk,
   input  logic        nrst,
   input  logic        load,
   output logic        ready,
   input  logic [7:0]  digits,
   input  logic [1:0]  dp,
   input  logic        blank,
   output logic        bp,
   output logic [15:0] seg
);

   localparam logic [11:0] CNT_MAX = 12'(BP_DIV - 1);

   logic [11:0] cnt_q, cnt_d;
   logic        bp_q, bp_d;
   logic [15:0] seg_q, seg_d;
   logic [15:0] active_q, active_d;
   disp_req_t   pend_q, pend_d;
   state_e      state_q, state_d;

   logic        wrap;
   logic        boundary;
   logic [6:0]  tensRaw;
   logic [6:0]  onesRaw;
   logic [6:0]  tensSeg;
   logic [15:0] pendPattern;

   assign wrap     = (cnt_q == CNT_MAX);
   assign boundary = wrap & bp_q;
   assign ready    = (state_q == ST_IDLE);
   assign bp       = bp_q;
   assign seg      = seg_q;

   bcd7seg u_tens (
      .bcd_i (pend_q.digits[7:4]),
      .seg_o (tensRaw)
   );

   bcd7seg u_ones (
      .bcd_i (pend_q.digits[3:0]),
      .seg_o (onesRaw)
   );

   // Build the 16-bit pattern the pending request would show, including
   // leading-zero suppression and the global blank override.
   always_comb begin
      tensSeg = tensRaw;
      if (BLANK_LZ && (pend_q.digits[7:4] == 4'd0)) begin
         tensSeg = SEG_BLANK;
      end
      pendPattern = {pend_q.dp[1], tensSeg, pend_q.dp[0], onesRaw};
      if (pend_q.blank) begin
         pendPattern = 16'h0000;
      end
   end

   // Prescaler: count 0..BP_DIV-1 and flip the backplane on each wrap.
   always_comb begin
      cnt_d = cnt_q + 12'd1;
      bp_d  = bp_q;
      if (wrap) begin
         cnt_d = 12'd0;
         bp_d  = ~bp_q;
      end
   end

   // Handshake FSM: capture on accepted load, publish at the frame boundary.
   // A load arriving on the boundary cycle while IDLE waits a full frame.
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      active_d = active_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               pend_d.digits = digits;
               pend_d.dp     = dp;
               pend_d.blank  = blank;
               state_d       = ST_PEND;
            end
         end
         ST_PEND: begin
            if (boundary) begin
               active_d = pendPattern;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Segment pins are registered from next-state values so seg and bp
   // change on exactly the same edge with no skew between them.
   always_comb begin
      seg_d = active_d ^ {16{bp_d}};
   end

   // State registers; reset leaves the glass blank with bp low.
   always_ff @(posedge osc_sclk or negedge nrst) begin
      if (!nrst) begin
         cnt_q    <= 12'd0;
         bp_q     <= 1'b0;
         seg_q    <= 16'h0000;
         active_q <= 16'h0000;
         pend_q   <= '0;
         state_q  <= ST_IDLE;
      end else begin
         cnt_q    <= cnt_d;
         bp_q     <= bp_d;
         seg_q    <= seg_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         state_q  <= state_d;
      end
   end

endmodule

// File: tb/tb_lcd_static_drv.sv
// Bench for lcd_static_drv: one instance at BP_DIV=32 for the directed
// timing scenarios and one at BP_DIV=2 for fast back-to-back loads, both
// fed the same inputs and compared every cycle against a frame-level model.
module tb_lcd_static_drv;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        load = 1'b0;
   logic [7:0]  digits = 8'h00;
   logic [1:0]  dp = 2'b00;
   logic        blank = 1'b0;

   logic        ready0, bp0;
   logic [15:0] seg0;
   logic        ready1, bp1;
   logic [15:0] seg1;

   int checks = 0;
   int errors = 0;

   lcd_static_drv #(.BP_DIV(32), .BLANK_LZ(1'b1)) dut0 (
      .osc_sclk (clk),
      .nrst     (nrst),
      .load     (load),
      .ready    (ready0),
      .digits   (digits),
      .dp       (dp),
      .blank    (blank),
      .bp       (bp0),
      .seg      (seg0)
   );

   lcd_static_drv #(.BP_DIV(2), .BLANK_LZ(1'b1)) dut1 (
      .osc_sclk (clk),
      .nrst     (nrst),
      .load     (load),
      .ready    (ready1),
      .digits   (digits),
      .dp       (dp),
      .blank    (blank),
      .bp       (bp1),
      .seg      (seg1)
   );

   // Free-running oscillator stand-in.
   always #5 clk = ~clk;

   // Model state: edges since reset release, shown pattern, pending request.
   int          bpd [2] = '{32, 2};
   int          n [2];
   logic [15:0] mAct [2];
   logic        mPendV [2];
   logic [7:0]  mDig [2];
   logic [1:0]  mDp [2];
   logic        mBlk [2];
   logic        mBnd [2];

   logic [6:0] segTbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   // Displayed pattern for a request, straight from the digit table.
   function automatic logic [15:0] refPattern(input logic [7:0] d, input logic [1:0] p,
                                              input logic b);
      logic [6:0] t;
      t = (d[7:4] == 4'd0) ? 7'h00 : segTbl[d[7:4]];
      if (b) return 16'h0000;
      return {p[1], t, p[0], segTbl[d[3:0]]};
   endfunction

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare one instance against the model after an edge.
   task automatic checkDut(input int k);
      logic        expBp;
      logic [15:0] expSeg;
      expBp  = ((n[k] / bpd[k]) % 2) == 1;
      expSeg = mAct[k] ^ {16{expBp}};
      if (k == 0) begin
         checkOutput($sformatf("bp0@%0d", n[0]), {15'd0, bp0}, {15'd0, expBp});
         checkOutput($sformatf("seg0@%0d", n[0]), seg0, expSeg);
         checkOutput($sformatf("ready0@%0d", n[0]), {15'd0, ready0}, {15'd0, !mPendV[0]});
      end else begin
         checkOutput($sformatf("bp1@%0d", n[1]), {15'd0, bp1}, {15'd0, expBp});
         checkOutput($sformatf("seg1@%0d", n[1]), seg1, expSeg);
         checkOutput($sformatf("ready1@%0d", n[1]), {15'd0, ready1}, {15'd0, !mPendV[1]});
      end
   endtask

   // Advance the model by one edge using the current inputs, clock, check.
   task automatic applyStimulus();
      for (int k = 0; k < 2; k++) begin
         int   m;
         logic rdy;
         m       = n[k] + 1;
         rdy     = !mPendV[k];
         mBnd[k] = (m % (2 * bpd[k])) == 0;
         if (mBnd[k] && mPendV[k]) begin
            mAct[k]   = refPattern(mDig[k], mDp[k], mBlk[k]);
            mPendV[k] = 1'b0;
         end
         if (load && rdy) begin
            mDig[k]   = digits;
            mDp[k]    = dp;
            mBlk[k]   = blank;
            mPendV[k] = 1'b1;
         end
         n[k] = m;
      end
      @(posedge clk);
      #1;
      checkDut(0);
      checkDut(1);
   endtask

   // Asynchronous reset: outputs must clear without any clock edge.
   task automatic applyReset();
      load = 1'b0;
      nrst = 1'b0;
      #1;
      checkOutput("rst_seg0", seg0, 16'h0000);
      checkOutput("rst_bp0", {15'd0, bp0}, 16'h0000);
      checkOutput("rst_ready0", {15'd0, ready0}, 16'h0001);
      checkOutput("rst_seg1", seg1, 16'h0000);
      checkOutput("rst_bp1", {15'd0, bp1}, 16'h0000);
      checkOutput("rst_ready1", {15'd0, ready1}, 16'h0001);
      for (int k = 0; k < 2; k++) begin
         n[k]      = 0;
         mAct[k]   = 16'h0000;
         mPendV[k] = 1'b0;
         mDig[k]   = 8'h00;
         mDp[k]    = 2'b00;
         mBlk[k]   = 1'b0;
         mBnd[k]   = 1'b0;
      end
      @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   // Step until the slow instance reaches a frame boundary (bounded).
   task automatic waitBoundary();
      logic found;
      found = 1'b0;
      for (int i = 0; i < 66 && !found; i++) begin
         applyStimulus();
         found = mBnd[0];
      end
      checkOutput("boundary_wait", {15'd0, found}, 16'h0001);
   endtask

   // Single-cycle load pulse.
   task automatic loadValue(input logic [7:0] d, input logic [1:0] p, input logic b);
      digits = d;
      dp     = p;
      blank  = b;
      load   = 1'b1;
      applyStimulus();
      load   = 1'b0;
      blank  = 1'b0;
   endtask

   initial begin
      #2;
      // Idle after reset: blank glass, bp toggling every 32 edges.
      applyReset();
      for (int i = 0; i < 200; i++) begin
         applyStimulus();
         if (n[0] == 32) checkOutput("bp_first_toggle", {15'd0, bp0}, 16'h0001);
      end

      // Load 0x42 on edge 10, visible from edge 64.
      applyReset();
      for (int i = 0; i < 9; i++) applyStimulus();
      loadValue(8'h42, 2'b00, 1'b0);
      checkOutput("ready_low_after_load", {15'd0, ready0}, 16'h0000);
      for (int i = 0; i < 54; i++) applyStimulus();
      checkOutput("seg_42_bp0", seg0, 16'h665B);
      checkOutput("bp_low_at_boundary", {15'd0, bp0}, 16'h0000);
      applyStimulus();
      checkOutput("ready_back", {15'd0, ready0}, 16'h0001);
      for (int i = 0; i < 31; i++) applyStimulus();
      checkOutput("seg_42_bp1", seg0, 16'h99A4);

      // Leading-zero blanking keeps the tens dp; non-BCD shows dashes.
      loadValue(8'h07, 2'b10, 1'b0);
      waitBoundary();
      checkOutput("seg_07_dp", seg0, 16'h8007);
      loadValue(8'hAF, 2'b00, 1'b0);
      waitBoundary();
      checkOutput("seg_AF_dash", seg0, 16'h4040);

      // Load while busy is ignored; retry after ready returns.
      loadValue(8'h12, 2'b00, 1'b0);
      digits = 8'h99;
      load   = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus();
      load = 1'b0;
      waitBoundary();
      checkOutput("seg_first_kept", seg0, 16'h065B);
      loadValue(8'h99, 2'b00, 1'b0);
      waitBoundary();
      checkOutput("seg_99", seg0, 16'h6F6F);

      // Blank request, then reset while a value is pending.
      loadValue(8'h88, 2'b11, 1'b1);
      waitBoundary();
      checkOutput("seg_blank", seg0, 16'h0000);
      loadValue(8'h35, 2'b01, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus();
      applyReset();
      for (int i = 0; i < 150; i++) applyStimulus();

      // Random back-to-back loads, mostly for the fast instance.
      for (int i = 0; i < 400; i++) begin
         load   = ($urandom_range(0, 3) != 0);
         digits = 8'($urandom);
         dp     = 2'($urandom);
         blank  = ($urandom_range(0, 7) == 0);
         applyStimulus();
      end
      load  = 1'b0;
      blank = 1'b0;
      for (int i = 0; i < 70; i++) applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
